// File: rtl/ifetch_stage.sv
// ifetch_stage -- instruction fetch stage feeding decode.
//   Owns the 64-bit PC, issues word fetches to instruction memory, buffers the
//   in-order responses tagged with their PC, and hands {instr, pc} to decode
//   over valid/ready. Branch redirects flush the buffer and drop wrong-path
//   responses still in flight.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr   fetch request channel (addr held while stalled)
//   imem_resp_valid, imem_resp_data   in-order fetch responses, latency >= 1
//   dec_valid/ready, dec_instr/pc     instruction + PC to decode
//   redirect_valid, redirect_pc       taken branch: flush and refetch from target
//   stall_cycles                      cycles without dec_valid (counter only built
//                                     when IFETCH_STALL_CNT_EN is defined, else 0)

// ifetch_fifo: small synchronous FIFO with head read directly from registers.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: none internally; callers keep push/pop within count (flush beats both).
module ifetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;

  // Storage carries no reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Push and pop on a full FIFO both land: the write targets the slot being
  // read out this cycle, so count stays put and no data is lost.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign headData = mem[rdPtr];
endmodule

// ifetch_stage: PC owner, fetch request issue, response buffering to decode.
// Latency: >= 2 cycles from request to dec_valid (request + memory + buffer write).
// Backpressure: requests gated by credits (outstanding + buffered < FIFO_DEPTH); dec head holds while !dec_ready.
module ifetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [63:0] dec_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [31:0] stall_cycles
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = CW + 1;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t        state;
  logic [63:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] dropCnt;
  logic [CW-1:0] dropNext;
  logic [CW-1:0] fifoCount;
  logic [CW-1:0] tagCount;
  logic [IW-1:0] inUse;
  logic [63:0]   tagHead;
  logic [95:0]   fifoHead;
  logic          reqFire;
  logic          respKeep;
  logic          decPop;

  // Every in-flight request already owns a buffer slot, so the FIFO cannot overflow.
  assign inUse          = {1'b0, outstanding} + {1'b0, fifoCount};
  assign imem_req_valid = !rst && (state == RUN) && (inUse < IW'(FIFO_DEPTH)) && !redirect_valid;
  assign imem_addr      = pc;
  assign reqFire        = imem_req_valid && imem_req_ready;

  // A response is kept only when nothing is left to drop; wrong-path
  // responses never had a live tag since the redirect flushed the tag queue.
  assign respKeep = imem_resp_valid && (dropCnt == '0) && (tagCount != '0) && !redirect_valid;
  assign decPop   = dec_valid && dec_ready;

  // On redirect every request still outstanding after this cycle's response
  // is wrong-path; in DRAIN that number already equals dropCnt.
  always_comb begin
    dropNext = dropCnt;
    if (redirect_valid) begin
      dropNext = outstanding - CW'(imem_resp_valid);
    end else if (imem_resp_valid && (dropCnt != '0)) begin
      dropNext = dropCnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      outstanding <= outstanding + CW'(reqFire) - CW'(imem_resp_valid);
      dropCnt     <= dropNext;
      state       <= (dropNext != '0) ? DRAIN : RUN;
      if (redirect_valid) begin
        pc <= redirect_pc & ~64'h3;
      end else if (reqFire) begin
        pc <= pc + 64'd4;
      end
    end
  end

  // PC of each accepted request, consumed in order as kept responses return.
  ifetch_fifo #(
    .WIDTH(64),
    .DEPTH(FIFO_DEPTH)
  ) tagQueue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (reqFire),
    .pushData (pc),
    .pop      (respKeep),
    .headData (tagHead),
    .count    (tagCount)
  );

  ifetch_fifo #(
    .WIDTH(96),
    .DEPTH(FIFO_DEPTH)
  ) instrQueue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (respKeep),
    .pushData ({imem_resp_data, tagHead}),
    .pop      (decPop),
    .headData (fifoHead),
    .count    (fifoCount)
  );

  assign dec_valid = (fifoCount != '0);
  assign dec_instr = fifoHead[95:64];
  assign dec_pc    = fifoHead[63:0];

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stallCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (!dec_valid && (stallCnt != 32'hFFFF_FFFF)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

  assign stall_cycles = stallCnt;
`else
  assign stall_cycles = 32'h0;
`endif
endmodule
